// File: rtl/cr_cg_ob_rx.sv
// Receive end of the CG outbound AXI4-stream path: DEPTH-beat FIFO, frame counter, source protocol monitor.
// Optional macro CR_CG_OB_RX_STALL_CNT_EN adds a saturating downstream-stall cycle counter (stall_cnt).
module cr_cg_ob_rx #(
    parameter int DEPTH  = 4,
    parameter int FCNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    input  logic              s_tid,
    input  logic [7:0]        s_tstrb,
    input  logic [7:0]        s_tuser,
    input  logic [63:0]       s_tdata,
    output logic              s_tready,
    output logic              m_tvalid,
    output logic              m_tlast,
    output logic              m_tid,
    output logic [7:0]        m_tstrb,
    output logic [7:0]        m_tuser,
    output logic [63:0]       m_tdata,
    input  logic              m_tready,
    input  logic              err_clr,
    output logic [FCNT_W-1:0] frame_cnt,
    output logic              proto_err,
`ifdef CR_CG_OB_RX_STALL_CNT_EN
    output logic              proto_int,
    output logic [31:0]       stall_cnt
`else
    output logic              proto_int
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic        last;
        logic        id;
        logic [7:0]  strb;
        logic [7:0]  user;
        logic [63:0] data;
    } beat_t;

    beat_t             mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic [FCNT_W-1:0] frame_cnt_q;
    logic              stall_q;
    beat_t             cap_q;
    logic              proto_err_q;
    logic              proto_int_q;

    beat_t in_beat;
    beat_t head;
    logic  push;
    logic  pop;
    logic  viol;

    // Handshake: a beat moves on a cycle where valid and ready are both high at the
    // clock edge; ready never depends combinationally on valid on either side.
    assign s_tready = (count_q != (AW + 1)'(DEPTH));
    assign m_tvalid = (count_q != '0);
    assign push     = s_tvalid & s_tready;
    assign pop      = m_tvalid & m_tready;

    assign in_beat = {s_tlast, s_tid, s_tstrb, s_tuser, s_tdata};
    assign head    = mem_q[rd_ptr_q];
    assign m_tlast = head.last;
    assign m_tid   = head.id;
    assign m_tstrb = head.strb;
    assign m_tuser = head.user;
    assign m_tdata = head.data;

    assign frame_cnt = frame_cnt_q;
    assign proto_err = proto_err_q;
    assign proto_int = proto_int_q;

    // A stalled offer seen last cycle must still be offered, unchanged, this cycle.
    assign viol = stall_q & (~s_tvalid | (in_beat != cap_q));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            frame_cnt_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_beat;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
                if (s_tlast) begin
                    frame_cnt_q <= frame_cnt_q + 1'b1;
                end
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q     <= 1'b0;
            cap_q       <= '0;
            proto_err_q <= 1'b0;
            proto_int_q <= 1'b0;
        end else begin
            stall_q <= s_tvalid & ~s_tready;
            if (s_tvalid & ~s_tready) begin
                cap_q <= in_beat;
            end
            proto_int_q <= viol;
            // A new violation outranks a simultaneous clear.
            proto_err_q <= viol | (proto_err_q & ~err_clr);
        end
    end

`ifdef CR_CG_OB_RX_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    assign stall_cnt = stall_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (err_clr) begin
            stall_cnt_q <= '0;
        end else if (m_tvalid & ~m_tready & (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end
`endif

endmodule

// File: doc/cr_cg_ob_rx.md
Name: cr_cg_ob_rx

Overview:
- Receive end of the CG outbound AXI4-stream datapath interface. Accepts beats from the CG core output bus and owns the ready path back to it.
- Buffers beats in a small FIFO, forwards them downstream with full valid/ready handshake, and counts frames.
- Monitors AXI4-stream source-side protocol rules and raises a sticky error plus a one-cycle interrupt pulse.
- Sits between the CG core output and the next stage of the engine pipeline.

Parameters:
- DEPTH, 4, FIFO depth in beats; power of two, minimum 2.
- FCNT_W, 16, width of the frame counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_tvalid  in  1  upstream beat valid.
- s_tlast  in  1  upstream end of frame.
- s_tid  in  1  upstream stream id.
- s_tstrb  in  8  upstream byte strobes.
- s_tuser  in  8  upstream sideband.
- s_tdata  in  64  upstream data.
- s_tready  out  1  ready back to upstream.
- m_tvalid  out  1  downstream beat valid.
- m_tlast  out  1  downstream end of frame.
- m_tid  out  1  downstream stream id.
- m_tstrb  out  8  downstream byte strobes.
- m_tuser  out  8  downstream sideband.
- m_tdata  out  64  downstream data.
- m_tready  in  1  downstream ready.
- err_clr  in  1  clears the sticky protocol error.
- frame_cnt  out  FCNT_W  count of accepted tlast beats.
- proto_err  out  1  sticky protocol-violation flag.
- proto_int  out  1  one-cycle pulse on a new protocol violation.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - FIFO empty.
  - s_tready=1, m_tvalid=0.
  - All m_t* payload outputs = 0.
  - frame_cnt=0, proto_err=0, proto_int=0.
- Push occurs when s_tvalid & s_tready. Pop occurs when m_tvalid & m_tready.
- s_tready = !full. It comes from a registered occupancy count, so there is no combinational path from m_tready to s_tready.
  - When full, a pop does not open s_tready in the same cycle; s_tready rises the following cycle.
- m_tvalid = !empty. Payload is driven from the FIFO head register.
  - Latency: a beat pushed in cycle N is first visible on m_t* in cycle N+1.
  - No bypass path.
- Simultaneous push and pop when not full and not empty: occupancy unchanged, both pointers advance.
- Simultaneous push and pop when empty: impossible in the same cycle because m_tvalid=0.
- Pointers are log2(DEPTH) bits and wrap naturally. Occupancy is log2(DEPTH)+1 bits.
- While m_tvalid=1 and m_tready=0, m_t* are held stable.
- frame_cnt increments by 1 on each push with s_tlast=1. It wraps from all-ones to 0 with no saturation.
- Protocol monitor, evaluated each cycle:
  - A capture register holds the upstream state when s_tvalid=1 and s_tready=0 (stalled offer).
  - Violation A: in the next cycle, s_tvalid=0 before the offer was accepted.
  - Violation B: in the next cycle, any of s_tlast/s_tid/s_tstrb/s_tuser/s_tdata changed while still stalled.
  - On either violation:
    - proto_int pulses for 1 cycle.
    - proto_err is set to 1 and stays set.
    - Data flow continues unaffected; the beat is pushed whenever it is accepted.
- err_clr=1 clears proto_err the next cycle.
- If err_clr and a new violation occur in the same cycle, the violation wins: proto_err stays 1 and proto_int pulses.
- s_tvalid=1 while full is not a violation by itself.

Optional Feature:
- Macro: CR_CG_OB_RX_STALL_CNT_EN.
- When defined:
  - Adds output stall_cnt (out, 32 bits).
  - stall_cnt increments each cycle m_tvalid=1 and m_tready=0. It saturates at 0xFFFFFFFF and is reset to 0.
  - err_clr also clears stall_cnt.
- When not defined: no stall_cnt port and no counter logic; all other behaviour is identical.

Test Plan:
- Single beat: after reset, push one beat with tdata=0x0123456789ABCDEF, tlast=1, m_tready=1.
  - m_tvalid=1 with identical payload exactly 1 cycle later.
  - frame_cnt=1, proto_err=0.
- Fill/backpressure: m_tready=0, offer 6 consecutive beats.
  - 4 accepted, then s_tready=0.
  - Raise m_tready: beats exit in order.
  - s_tready returns to 1 one cycle after the first pop.
- Streaming: m_tready=1, s_tvalid=1 continuously for 100 beats, every 10th beat with tlast.
  - Throughput of 1 beat/cycle after the first.
  - frame_cnt=10; no data loss or reordering.
- Violation A: stall with FIFO full, drop s_tvalid before acceptance.
  - proto_int high for 1 cycle, proto_err=1.
  - Pulse err_clr: proto_err=0 next cycle.
- Violation B: stalled offer, change s_tdata from 0xAA to 0xBB while still stalled.
  - proto_int pulse.
  - Assert err_clr on the same cycle as a second violation: proto_err stays 1.
- Wrap and reset: with FCNT_W=4, send 17 frames, expect frame_cnt=1.
  - Assert rst_n=0 mid-frame with the FIFO holding 3 beats: all outputs return to reset values immediately; FIFO empty after release.
